// File: rtl/block_list_ctrl.sv
// IPv4 block-list table shared between the frame lookup path and the management port.
// One table entry is examined per clock; all operations are serialised by a single FSM.
module block_list_ctrl #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [31:0]      lk_src_ip,
  input  logic [31:0]      lk_dst_ip,
  output logic             lk_done,
  output logic             lk_block,
  output logic [IDX_W-1:0] lk_hit_idx,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_op,
  input  logic [31:0]      cfg_ip,
  output logic             cfg_done,
  output logic [1:0]       cfg_status,
  output logic [IDX_W:0]   entry_count,
  output logic             busy
);

  localparam logic [1:0] OP_DEL       = 2'b01;
  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_DUP       = 2'b01;
  localparam logic [1:0] ST_FULL      = 2'b10;
  localparam logic [1:0] ST_NOT_FOUND = 2'b11;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    IDLE, LK_SCAN, CFG_SCAN, CFG_WRITE, DONE_LK, DONE_CFG
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic                   r_prio;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_ENTRIES-1:0] r_valid;
  logic [31:0]            r_ip [NUM_ENTRIES];
  logic [31:0]            r_src;
  logic [31:0]            r_dst;
  logic [31:0]            r_cfg_ip;
  logic                   r_is_del;
  logic                   r_dup;
  logic                   r_free_found;
  logic [IDX_W-1:0]       r_free_idx;
  logic [IDX_W-1:0]       r_tgt_idx;
  logic [1:0]             r_pend_status;
  logic                   r_lk_block;
  logic [IDX_W-1:0]       r_lk_hit_idx;
  logic [1:0]             r_cfg_status;
  logic [IDX_W:0]         r_count;

  logic             w_idle;
  logic             w_lk_grant;
  logic             w_cfg_grant;
  logic [IDX_W-1:0] w_addr;
  logic [31:0]      w_rd_ip;
  logic             w_rd_valid;
  logic             w_last;
  logic             w_lk_hit;
  logic             w_cfg_match;
  logic             w_add_ok;

  // r_prio = 0 favours the lookup path, 1 favours the config port.
  assign w_idle      = (r_state == IDLE);
  assign w_lk_grant  = w_idle && lk_valid && (!cfg_valid || !r_prio);
  assign w_cfg_grant = w_idle && cfg_valid && (!lk_valid || r_prio);

  // The table has a single port: the write address is used only in CFG_WRITE.
  assign w_addr      = (r_state == CFG_WRITE) ? r_tgt_idx : r_idx;
  assign w_rd_ip     = r_ip[w_addr];
  assign w_rd_valid  = r_valid[w_addr];
  assign w_last      = (r_idx == LAST_IDX);
  assign w_lk_hit    = w_rd_valid && ((w_rd_ip == r_src) || (w_rd_ip == r_dst));
  assign w_cfg_match = w_rd_valid && (w_rd_ip == r_cfg_ip);
  assign w_add_ok    = (r_state == CFG_WRITE) && !r_is_del && (r_pend_status == ST_OK);

  assign lk_block    = r_lk_block;
  assign lk_hit_idx  = r_lk_hit_idx;
  assign cfg_status  = r_cfg_status;
  assign entry_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    lk_ready     = 1'b0;
    cfg_ready    = 1'b0;
    lk_done      = 1'b0;
    cfg_done     = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy      = 1'b0;
        lk_ready  = !cfg_valid || !r_prio;
        cfg_ready = !lk_valid || r_prio;
        if (w_lk_grant) begin
          w_next_state = LK_SCAN;
        end else if (w_cfg_grant) begin
          w_next_state = cfg_op[1] ? DONE_CFG : CFG_SCAN;
        end
      end
      LK_SCAN: begin
        if (w_lk_hit || w_last) begin
          w_next_state = DONE_LK;
        end
      end
      CFG_SCAN: begin
        if (r_is_del) begin
          if (w_cfg_match) begin
            w_next_state = CFG_WRITE;
          end else if (w_last) begin
            w_next_state = DONE_CFG;
          end
        end else if (w_last) begin
          w_next_state = CFG_WRITE;
        end
      end
      CFG_WRITE: w_next_state = DONE_CFG;
      DONE_LK: begin
        lk_done      = 1'b1;
        w_next_state = IDLE;
      end
      DONE_CFG: begin
        cfg_done     = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio        <= 1'b0;
      r_idx         <= '0;
      r_valid       <= '0;
      r_src         <= '0;
      r_dst         <= '0;
      r_cfg_ip      <= '0;
      r_is_del      <= 1'b0;
      r_dup         <= 1'b0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
      r_tgt_idx     <= '0;
      r_pend_status <= ST_OK;
      r_lk_block    <= 1'b0;
      r_lk_hit_idx  <= '0;
      r_cfg_status  <= ST_OK;
      r_count       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_idx        <= '0;
          r_dup        <= 1'b0;
          r_free_found <= 1'b0;
          r_free_idx   <= '0;
          if (w_lk_grant) begin
            r_src  <= lk_src_ip;
            r_dst  <= lk_dst_ip;
            r_prio <= 1'b1;
          end else if (w_cfg_grant) begin
            r_cfg_ip <= cfg_ip;
            r_is_del <= (cfg_op == OP_DEL);
            r_prio   <= 1'b0;
            if (cfg_op[1]) begin
              r_valid      <= '0;
              r_count      <= '0;
              r_cfg_status <= ST_OK;
            end
          end
        end
        LK_SCAN: begin
          r_idx <= r_idx + IDX_W'(1);
          if (w_lk_hit) begin
            r_lk_block   <= 1'b1;
            r_lk_hit_idx <= r_idx;
          end else if (w_last) begin
            r_lk_block   <= 1'b0;
            r_lk_hit_idx <= '0;
          end
        end
        CFG_SCAN: begin
          r_idx <= r_idx + IDX_W'(1);
          if (r_is_del) begin
            if (w_cfg_match) begin
              r_tgt_idx     <= r_idx;
              r_pend_status <= ST_OK;
            end else if (w_last) begin
              r_cfg_status <= ST_NOT_FOUND;
            end
          end else begin
            if (w_cfg_match) begin
              r_dup <= 1'b1;
            end
            if (!w_rd_valid && !r_free_found) begin
              r_free_found <= 1'b1;
              r_free_idx   <= r_idx;
            end
            // Final verdict folds in the last entry, which is not yet in r_dup/r_free_*.
            if (w_last) begin
              if (r_dup || w_cfg_match) begin
                r_pend_status <= ST_DUP;
              end else if (!r_free_found && w_rd_valid) begin
                r_pend_status <= ST_FULL;
              end else begin
                r_pend_status <= ST_OK;
                r_tgt_idx     <= r_free_found ? r_free_idx : r_idx;
              end
            end
          end
        end
        CFG_WRITE: begin
          r_cfg_status <= r_pend_status;
          if (r_pend_status == ST_OK) begin
            if (r_is_del) begin
              r_valid[r_tgt_idx] <= 1'b0;
              r_count            <= r_count - {{IDX_W{1'b0}}, 1'b1};
            end else begin
              r_valid[r_tgt_idx] <= 1'b1;
              r_count            <= r_count + {{IDX_W{1'b0}}, 1'b1};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // IP storage carries no reset; an entry only counts once its valid bit is set.
  always_ff @(posedge clk) begin
    if (w_add_ok) begin
      r_ip[r_tgt_idx] <= r_cfg_ip;
    end
  end

endmodule

// File: tb/tb_block_list_ctrl.sv
// Self-checking bench for block_list_ctrl: directed scenarios plus randomized ops
// compared against a plain array model of the block list.
module tb_block_list_ctrl;
  localparam int N  = 16;
  localparam int IW = 4;
  localparam logic [1:0] OP_ADD = 2'b00, OP_DEL = 2'b01, OP_CLR = 2'b10, OP_RSV = 2'b11;
  localparam logic [1:0] ST_OK = 2'b00, ST_DUP = 2'b01, ST_FULL = 2'b10, ST_NF = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lk_valid = 1'b0;
  logic          lk_ready;
  logic [31:0]   lk_src_ip = '0;
  logic [31:0]   lk_dst_ip = '0;
  logic          lk_done;
  logic          lk_block;
  logic [IW-1:0] lk_hit_idx;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_op = '0;
  logic [31:0]   cfg_ip = '0;
  logic          cfg_done;
  logic [1:0]    cfg_status;
  logic [IW:0]   entry_count;
  logic          busy;

  int nCompared   = 0;
  int nMismatched = 0;

  bit          mValid [N];
  logic [31:0] mIp [N];
  int          mCount;

  always #4 clk = ~clk;

  block_list_ctrl dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_src_ip(lk_src_ip), .lk_dst_ip(lk_dst_ip),
    .lk_done(lk_done), .lk_block(lk_block), .lk_hit_idx(lk_hit_idx),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op), .cfg_ip(cfg_ip),
    .cfg_done(cfg_done), .cfg_status(cfg_status), .entry_count(entry_count), .busy(busy)
  );

  // Reference model: first valid slot whose IP equals either address.
  function automatic void modelLookup(input logic [31:0] s, input logic [31:0] d,
                                      output logic blk, output int idx);
    blk = 1'b0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      if (mValid[i] && (mIp[i] == s || mIp[i] == d)) begin
        blk = 1'b1;
        idx = i;
        break;
      end
    end
  endfunction

  function automatic logic [1:0] modelCfg(input logic [1:0] op, input logic [31:0] ip,
                                          output int slot);
    slot = -1;
    if (op[1]) begin
      for (int i = 0; i < N; i++) mValid[i] = 1'b0;
      mCount = 0;
      return ST_OK;
    end
    for (int i = 0; i < N; i++) begin
      if (mValid[i] && mIp[i] == ip) begin
        if (op == OP_DEL) begin
          mValid[i] = 1'b0;
          mCount--;
          slot = i;
          return ST_OK;
        end
        return ST_DUP;
      end
    end
    if (op == OP_DEL) return ST_NF;
    for (int i = 0; i < N; i++) begin
      if (!mValid[i]) begin
        mValid[i] = 1'b1;
        mIp[i] = ip;
        mCount++;
        slot = i;
        return ST_OK;
      end
    end
    return ST_FULL;
  endfunction

  task automatic doReset();
    lk_valid  = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) mValid[i] = 1'b0;
    mCount = 0;
  endtask

  // Latency counts negedges from the acceptance edge up to the first one showing done.
  task automatic doLookup(input logic [31:0] s, input logic [31:0] d, output int lat,
                          output logic blk, output logic [IW-1:0] idx, output bit ok);
    int n;
    ok = 1'b1; lat = 0; blk = 1'b0; idx = '0; n = 0;
    @(negedge clk);
    lk_valid = 1'b1; lk_src_ip = s; lk_dst_ip = d;
    #1;
    while (!lk_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!lk_ready) begin ok = 1'b0; lk_valid = 1'b0; return; end
    @(posedge clk);
    #1 lk_valid = 1'b0;
    do begin @(negedge clk); lat++; end while (!lk_done && lat < 200);
    if (!lk_done) ok = 1'b0;
    blk = lk_block;
    idx = lk_hit_idx;
  endtask

  task automatic doCfg(input logic [1:0] op, input logic [31:0] ip, output int lat,
                       output logic [1:0] st, output bit ok);
    int n;
    ok = 1'b1; lat = 0; st = '0; n = 0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_op = op; cfg_ip = ip;
    #1;
    while (!cfg_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!cfg_ready) begin ok = 1'b0; cfg_valid = 1'b0; return; end
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    do begin @(negedge clk); lat++; end while (!cfg_done && lat < 200);
    if (!cfg_done) ok = 1'b0;
    st = cfg_status;
  endtask

  task automatic test_reset();
    int lat; logic [1:0] st; bit ok; logic blk; logic [IW-1:0] idx; int slot;
    doReset();
    #1;
    nCompared++;
    if ({lk_done, cfg_done, lk_block, lk_hit_idx, cfg_status, entry_count, busy} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got done=%b/%b blk=%b idx=%0d st=%0d cnt=%0d busy=%b want all 0",
               lk_done, cfg_done, lk_block, lk_hit_idx, cfg_status, entry_count, busy);
    end
    nCompared++;
    if ({lk_ready, cfg_ready} !== 2'b11) begin
      nMismatched++;
      $display("[TB] FAIL reset_ready: got %b want 11", {lk_ready, cfg_ready});
    end
    doCfg(OP_ADD, 32'h01010101, lat, st, ok);
    st = modelCfg(OP_ADD, 32'h01010101, slot);
    doCfg(OP_DEL, 32'h02020202, lat, st, ok);
    doLookup(32'h01010101, 32'h0, lat, blk, idx, ok);
    doReset();
    #1;
    nCompared++;
    if ({lk_block, cfg_status, entry_count} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_after_use: got blk=%b st=%0d cnt=%0d want 0/0/0",
               lk_block, cfg_status, entry_count);
    end
  endtask

  task automatic test_add_dup();
    int lat; logic [1:0] st; bit ok; int slot; logic [1:0] junk;
    doReset();
    doCfg(OP_ADD, 32'hC0A80101, lat, st, ok);
    junk = modelCfg(OP_ADD, 32'hC0A80101, slot);
    nCompared++;
    if (!ok || lat !== N + 2) begin
      nMismatched++;
      $display("[TB] FAIL add_latency: got %0d (ok=%0d) want %0d", lat, ok, N + 2);
    end
    nCompared++;
    if (st !== ST_OK || entry_count !== 1) begin
      nMismatched++;
      $display("[TB] FAIL add_status: got st=%0d cnt=%0d want st=0 cnt=1", st, entry_count);
    end
    doCfg(OP_ADD, 32'hC0A80101, lat, st, ok);
    junk = modelCfg(OP_ADD, 32'hC0A80101, slot);
    nCompared++;
    if (!ok || st !== ST_DUP || entry_count !== 1) begin
      nMismatched++;
      $display("[TB] FAIL add_dup: got st=%0d cnt=%0d want st=1 cnt=1", st, entry_count);
    end
  endtask

  task automatic test_lookup();
    int lat; bit ok; logic blk; logic [IW-1:0] idx;
    doLookup(32'hC0A80101, 32'h0A000001, lat, blk, idx, ok);
    nCompared++;
    if (!ok || lat !== 2 || blk !== 1'b1 || idx !== 0) begin
      nMismatched++;
      $display("[TB] FAIL lookup_hit0: got lat=%0d blk=%b idx=%0d want lat=2 blk=1 idx=0", lat, blk, idx);
    end
    doLookup(32'h0A000002, 32'h0A000002, lat, blk, idx, ok);
    nCompared++;
    if (!ok || lat !== N + 1 || blk !== 1'b0 || idx !== 0) begin
      nMismatched++;
      $display("[TB] FAIL lookup_miss: got lat=%0d blk=%b idx=%0d want lat=%0d blk=0 idx=0", lat, blk, idx, N + 1);
    end
  endtask

  task automatic test_full_del();
    int lat; logic [1:0] st; bit ok; int slot; logic [1:0] junk; logic blk; logic [IW-1:0] idx;
    doReset();
    for (int i = 0; i < N; i++) begin
      doCfg(OP_ADD, 32'h0A010000 + i, lat, st, ok);
      junk = modelCfg(OP_ADD, 32'h0A010000 + i, slot);
      nCompared++;
      if (!ok || st !== ST_OK || entry_count !== i + 1) begin
        nMismatched++;
        $display("[TB] FAIL fill_%0d: got st=%0d cnt=%0d want st=0 cnt=%0d", i, st, entry_count, i + 1);
      end
    end
    doCfg(OP_ADD, 32'h0A0100FF, lat, st, ok);
    junk = modelCfg(OP_ADD, 32'h0A0100FF, slot);
    nCompared++;
    if (!ok || st !== ST_FULL || entry_count !== N || lat !== N + 2) begin
      nMismatched++;
      $display("[TB] FAIL add_full: got st=%0d cnt=%0d lat=%0d want st=2 cnt=%0d lat=%0d", st, entry_count, lat, N, N + 2);
    end
    doCfg(OP_DEL, 32'h0A010005, lat, st, ok);
    junk = modelCfg(OP_DEL, 32'h0A010005, slot);
    nCompared++;
    if (!ok || st !== ST_OK || entry_count !== N - 1) begin
      nMismatched++;
      $display("[TB] FAIL del_idx5: got st=%0d cnt=%0d want st=0 cnt=%0d", st, entry_count, N - 1);
    end
    doCfg(OP_ADD, 32'hDEADBEEF, lat, st, ok);
    junk = modelCfg(OP_ADD, 32'hDEADBEEF, slot);
    doLookup(32'hDEADBEEF, 32'hDEADBEEF, lat, blk, idx, ok);
    nCompared++;
    if (!ok || blk !== 1'b1 || idx !== 5 || lat !== 7) begin
      nMismatched++;
      $display("[TB] FAIL refill_slot5: got blk=%b idx=%0d lat=%0d want blk=1 idx=5 lat=7", blk, idx, lat);
    end
  endtask

  task automatic test_notfound_clear();
    int lat; logic [1:0] st; bit ok; int slot; logic [1:0] junk; logic blk; logic [IW-1:0] idx;
    doCfg(OP_DEL, 32'h01020304, lat, st, ok);
    junk = modelCfg(OP_DEL, 32'h01020304, slot);
    nCompared++;
    if (!ok || st !== ST_NF || entry_count !== N) begin
      nMismatched++;
      $display("[TB] FAIL del_absent: got st=%0d cnt=%0d want st=3 cnt=%0d", st, entry_count, N);
    end
    doCfg(OP_CLR, 32'h0, lat, st, ok);
    junk = modelCfg(OP_CLR, 32'h0, slot);
    nCompared++;
    if (!ok || lat !== 1 || st !== ST_OK || entry_count !== 0) begin
      nMismatched++;
      $display("[TB] FAIL clear: got lat=%0d st=%0d cnt=%0d want lat=1 st=0 cnt=0", lat, st, entry_count);
    end
    for (int i = 0; i < N; i++) begin
      doLookup(32'h0A010000 + i, 32'hDEADBEEF, lat, blk, idx, ok);
      nCompared++;
      if (!ok || blk !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL cleared_lookup_%0d: got blk=%b want 0", i, blk);
      end
    end
    doCfg(OP_ADD, 32'h00000000, lat, st, ok);
    junk = modelCfg(OP_ADD, 32'h00000000, slot);
    doLookup(32'h00000000, 32'h12345678, lat, blk, idx, ok);
    nCompared++;
    if (!ok || blk !== 1'b1 || idx !== 0) begin
      nMismatched++;
      $display("[TB] FAIL zero_ip: got blk=%b idx=%0d want blk=1 idx=0", blk, idx);
    end
    doCfg(OP_RSV, 32'h0, lat, st, ok);
    junk = modelCfg(OP_RSV, 32'h0, slot);
    nCompared++;
    if (!ok || lat !== 1 || st !== ST_OK || entry_count !== 0) begin
      nMismatched++;
      $display("[TB] FAIL reserved_op: got lat=%0d st=%0d cnt=%0d want lat=1 st=0 cnt=0", lat, st, entry_count);
    end
  endtask

  task automatic test_arbitration();
    int nGrant; int cyc; int bothReady; int overlap; bit grantCfg; bit expCfg;
    doReset();
    nGrant = 0; cyc = 0; bothReady = 0; overlap = 0;
    lk_src_ip = 32'h11111111; lk_dst_ip = 32'h11111111;
    cfg_op = OP_DEL; cfg_ip = 32'h22222222;
    @(negedge clk);
    lk_valid = 1'b1; cfg_valid = 1'b1;
    #1;
    while (nGrant < 6 && cyc < 400) begin
      if (lk_done && cfg_done) overlap++;
      if (lk_ready || cfg_ready) begin
        if (lk_ready && cfg_ready) bothReady++;
        grantCfg = cfg_ready;
        expCfg = (nGrant % 2) == 1;
        nCompared++;
        if (grantCfg !== expCfg) begin
          nMismatched++;
          $display("[TB] FAIL arb_grant_%0d: got %s want %s", nGrant,
                   grantCfg ? "CFG" : "LK", expCfg ? "CFG" : "LK");
        end
        nGrant++;
      end
      @(negedge clk); #1; cyc++;
    end
    lk_valid = 1'b0; cfg_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      if (lk_done && cfg_done) overlap++;
      @(negedge clk); #1; cyc++;
    end
    nCompared++;
    if (nGrant !== 6 || bothReady !== 0 || overlap !== 0 || busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL arb_summary: got grants=%0d both=%0d overlap=%0d busy=%b want 6/0/0/0",
               nGrant, bothReady, overlap, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [1:0] st; bit ok; int slot; logic [1:0] junk; int n; bit seenDone;
    logic blk; logic [IW-1:0] idx;
    doReset();
    doCfg(OP_ADD, 32'hAC100001, lat, st, ok);
    junk = modelCfg(OP_ADD, 32'hAC100001, slot);
    n = 0; seenDone = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_op = OP_ADD; cfg_ip = 32'hAC100002;
    #1;
    while (!cfg_ready && n < 200) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    repeat (5) begin @(negedge clk); if (cfg_done) seenDone = 1'b1; end
    rst = 1'b1;
    @(negedge clk);
    if (cfg_done) seenDone = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) mValid[i] = 1'b0;
    mCount = 0;
    @(negedge clk); #1;
    nCompared++;
    if (lk_ready !== 1'b1 || cfg_ready !== 1'b1 || entry_count !== 0 || busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_state: got rdy=%b%b cnt=%0d busy=%b want 11/0/0",
               lk_ready, cfg_ready, entry_count, busy);
    end
    repeat (20) begin @(negedge clk); if (cfg_done) seenDone = 1'b1; end
    nCompared++;
    if (seenDone !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_done: got cfg_done seen=%b want 0", seenDone);
    end
    doLookup(32'hAC100001, 32'hAC100002, lat, blk, idx, ok);
    nCompared++;
    if (!ok || blk !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_table: got blk=%b want 0", blk);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [20];
    logic [31:0] rv; logic [31:0] s; logic [31:0] d;
    int r; int lat; int expLat; int expIdx; int slot; bit ok;
    logic [1:0] st; logic [1:0] expSt; logic [1:0] op; logic blk; logic expBlk; logic [IW-1:0] idx;
    pool[0] = 32'h0;
    for (int i = 1; i < 20; i++) begin
      rv = $urandom;
      pool[i] = {8'(i), rv[23:0]};
    end
    for (int it = 0; it < 90; it++) begin
      r = $urandom_range(0, 99);
      if (r < 40) begin
        rv = $urandom;
        s = ($urandom_range(0, 9) < 7) ? pool[$urandom_range(0, 19)] : {8'hFF, rv[23:0]};
        d = ($urandom_range(0, 9) < 5) ? pool[$urandom_range(0, 19)] : {8'hFE, rv[23:0]};
        modelLookup(s, d, expBlk, expIdx);
        expLat = expBlk ? expIdx + 2 : N + 1;
        doLookup(s, d, lat, blk, idx, ok);
        nCompared++;
        if (!ok || blk !== expBlk || idx !== IW'(expIdx) || lat !== expLat) begin
          nMismatched++;
          $display("[TB] FAIL rand_lookup_%0d: got blk=%b idx=%0d lat=%0d want blk=%b idx=%0d lat=%0d",
                   it, blk, idx, lat, expBlk, expIdx, expLat);
        end
      end else begin
        if (r < 75)      op = OP_ADD;
        else if (r < 95) op = OP_DEL;
        else             op = ($urandom_range(0, 1) == 1) ? OP_RSV : OP_CLR;
        s = pool[$urandom_range(0, 19)];
        expSt = modelCfg(op, s, slot);
        if (op[1])                expLat = 1;
        else if (op == OP_ADD)    expLat = N + 2;
        else if (expSt == ST_OK)  expLat = slot + 3;
        else                      expLat = -1;
        doCfg(op, s, lat, st, ok);
        nCompared++;
        if (!ok || st !== expSt || entry_count !== mCount || (expLat >= 0 && lat !== expLat)) begin
          nMismatched++;
          $display("[TB] FAIL rand_cfg_%0d: op=%0d got st=%0d cnt=%0d lat=%0d want st=%0d cnt=%0d lat=%0d",
                   it, op, st, entry_count, lat, expSt, mCount, expLat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_dup();
    test_lookup();
    test_full_del();
    test_notfound_clear();
    test_arbitration();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/block_list_ctrl.md
Name: block_list_ctrl

Overview:
- Owns the IPv4 block-list table and shares it between two requesters: the per-frame lookup path (parser to drop/forward decision) and a management/config port (add, delete, clear).
- Table holds NUM_ENTRIES slots, each a valid bit plus a 32-bit IP. IPs are stored in a single-port array, so exactly one entry is examined per cycle.
- Sits between the frame parser and the packet FSM. It replaces the statically initialised block list with a runtime-managed table.

Parameters:
- NUM_ENTRIES, 16: number of table slots (≥2).
- IDX_W, $clog2(NUM_ENTRIES): slot index width.

Ports:
- clk  input  1  system clock, 125 MHz
- rst  input  1  synchronous, active-high reset
- lk_valid  input  1  lookup request
- lk_ready  output  1  lookup request accepted when lk_valid && lk_ready
- lk_src_ip  input  32  source IP, sampled at acceptance
- lk_dst_ip  input  32  destination IP, sampled at acceptance
- lk_done  output  1  one-cycle pulse, lookup result valid
- lk_block  output  1  result: either IP matched a valid entry (held until next lk_done)
- lk_hit_idx  output  IDX_W  index of first matching entry (0 if no hit)
- cfg_valid  input  1  config request
- cfg_ready  output  1  config request accepted when cfg_valid && cfg_ready
- cfg_op  input  2  00 ADD, 01 DEL, 10 CLEAR, 11 reserved (treated as CLEAR)
- cfg_ip  input  32  IP operand, sampled at acceptance
- cfg_done  output  1  one-cycle pulse, op complete
- cfg_status  output  2  00 OK, 01 DUP, 10 FULL, 11 NOT_FOUND (held until next cfg_done)
- entry_count  output  IDX_W+1  number of valid entries
- busy  output  1  state != IDLE

Behaviour:
- Reset: all valid bits 0; entry_count 0; state IDLE. Outputs lk_done, cfg_done, lk_block, lk_hit_idx, cfg_status are all 0. Priority pointer favours lookup. Reset mid-operation aborts the operation with no done pulse and clears the table.
- States: IDLE, LK_SCAN, CFG_SCAN, CFG_WRITE, DONE_LK, DONE_CFG.
- Arbitration in IDLE:
  - lk_ready = IDLE && (!cfg_valid || prio==LK).
  - cfg_ready = IDLE && (!lk_valid || prio==CFG).
  - When both are requesting, the grant alternates. prio flips to the other requester after each grant. A sole requester is always granted.
  - Ready is never asserted outside IDLE.
- LK_SCAN: idx runs from 0 upward, one entry per cycle. Hit = valid[idx] && (ip[idx]==src || ip[idx]==dst). Scan stops at the first hit or after idx = NUM_ENTRIES-1.
  - The next cycle is DONE_LK: lk_done=1, lk_block and lk_hit_idx updated.
  - Latency from the acceptance edge to the lk_done cycle is k+2 cycles, where k = hit index or NUM_ENTRIES-1.
- ADD:
  - CFG_SCAN walks all NUM_ENTRIES entries, recording the lowest free index and detecting a duplicate.
  - Duplicate found → DUP, no write.
  - No free slot → FULL, no write.
  - Otherwise CFG_WRITE writes ip, sets valid, increments entry_count; status OK.
  - Latency is NUM_ENTRIES+2 cycles.
- DEL:
  - CFG_SCAN stops at the first valid match.
  - Match: CFG_WRITE clears its valid bit and decrements entry_count; status OK.
  - No match: NOT_FOUND, table unchanged.
- CLEAR: all valid bits cleared in one cycle and entry_count set to 0. cfg_done (OK) follows in the next cycle.
- Entry 0.0.0.0 is legal. Invalid slots never match regardless of stored IP.
- Lookups never observe a partially applied config op, because ops are serialised by the FSM.
- Requests that are deasserted before acceptance are ignored. Requesters hold inputs stable until accepted.
- lk_done and cfg_done are never asserted in the same cycle.

Test Plan:
1. Reset, then ADD C0A80101 → cfg_done after 18 cycles (NUM_ENTRIES=16), status OK, entry_count=1. Repeat the same ADD → status DUP, count stays 1.
2. Lookup src=C0A80101, dst=0A000001 after step 1 → lk_done 2 cycles after acceptance, lk_block=1, lk_hit_idx=0. Lookup src=dst=0A000002 → lk_done after 17 cycles, lk_block=0.
3. Fill 16 distinct IPs, then ADD a 17th → FULL, entry_count=16. DEL the entry at index 5 → OK, count 15. Next ADD lands in slot 5, confirmed by a lookup reporting hit_idx 5.
4. DEL of an absent IP → NOT_FOUND, count unchanged. CLEAR → cfg_done one cycle after acceptance, count 0, every prior IP now looks up with lk_block=0.
5. lk_valid and cfg_valid held continuously → grants alternate LK, CFG, LK, CFG…, with lookup first after reset, and neither requester starved.
6. Assert rst during an ADD scan → no cfg_done, table empty, entry_count=0, both ready high the cycle after rst deasserts.
